i2c_master: RTL and testbench
=============================

Name: i2c_master

Overview:
- Single-byte I2C controller (initiator), one per design; drives the bus towards the team's I2C responder.
- Accepts one write or read request per handshake and generates START, the 7-bit address plus R/W, one data byte, the ACK slots and STOP.
- Drives SCL and SDA open-drain: each output enable pulls its line low; released means the pull-up holds the line high.
- No clock stretching, no arbitration, no repeated START.

Parameters:
CLK_DIV, 4, clk cycles per quarter SCL period (legal range 1..255); one bit-time = 4*CLK_DIV cycles

Ports:
clk      in   1  system clock; all logic on its rising edge
rst      in   1  reset, asynchronous, active-high
start    in   1  request strobe; sampled only in IDLE
rw       in   1  0 = write, 1 = read; captured with start
addr     in   7  target address; captured with start
wdata    in   8  write byte; captured with start
busy     out  1  high from the cycle after start is accepted until done
done     out  1  one-cycle pulse when the transaction ends
ack_err  out  1  valid with done; 1 = an ACK slot was NACKed
rdata    out  8  read byte; valid from done until the next accepted start
scl_oe   out  1  1 = pull SCL low
sda_oe   out  1  1 = pull SDA low
sda_in   in   1  SDA line level; external 2-flop synchronizer, no internal sync

Behaviour:
- Reset values: busy=0, done=0, ack_err=0, rdata=0, scl_oe=0, sda_oe=0, FSM in IDLE, divider and counters 0.
- Reset mid-transfer releases both lines immediately; the bus is left as is and no STOP is sent.
- Quarter tick: divider counts 0..CLK_DIV-1 and asserts tick on wrap; 2-bit phase q advances on each tick.
- Every state below lasts exactly one bit-time (q0..q3).
- Data bit / ACK slot: q0 SCL low and SDA set up; q1-q2 SCL released; sample sda_in on the tick ending q2; q3 SCL low.
- Shift order is MSB first. Address byte = {addr, rw}.
- States:
  - IDLE: lines released. On start: capture inputs, clear ack_err, busy=1, go to START.
  - START: q0-q1 both lines released; q2-q3 SDA low with SCL high; SCL is pulled low at the next q0.
  - ADDR: 8 bits.
  - ADDR_ACK: SDA released; sampled 1 -> ack_err=1, go to STOP. Otherwise go to WRITE if rw=0, READ if rw=1.
  - WRITE: 8 bits of wdata.
  - WRITE_ACK: SDA released; sampled 1 -> ack_err=1; go to STOP either way.
  - READ: SDA released; shift in 8 bits; update rdata at the end of the 8th bit.
  - READ_NACK: SDA released (master NACK ends the read); go to STOP.
  - STOP: q0 SCL low, SDA low; q1-q2 SCL released, SDA low; q3 SDA released.
- End of STOP: done=1 for one cycle, busy=0, return to IDLE.
- Latency from the start cycle to done:
  - Full transaction: 1 + 20*4*CLK_DIV cycles.
  - Address NACK: 1 + 11*4*CLK_DIV cycles.
- start while busy is ignored; no queueing.
- start in the same cycle as done is ignored; it is accepted one cycle later.
- start held high in IDLE starts exactly one transaction per acceptance.
- CLK_DIV=1 must still produce correct phase ordering.

Decomposition:
- Package i2c_pkg: FSM state enum, R/W encoding constants (I2C_WRITE=0, I2C_READ=1), ACK level constant.
- Sub-module i2c_clk_div: parameterised quarter-tick generator with cleared counter.

Test Plan:
- Write, CLK_DIV=4, addr=0x55, rw=0, wdata=0xA5, model ACKs both slots:
  - SDA bits at SCL rise: 1,0,1,0,1,0,1,0 | 0 | 1,0,1,0,0,1,0,1 | 0.
  - done at cycle 321 after start; ack_err=0.
- Read, addr=0x55, rw=1, model returns 0x3C:
  - rdata=0x3C at done.
  - SDA released in the 9th data slot.
  - ack_err=0.
- Address NACK, model never drives SDA:
  - ack_err=1; STOP follows ADDR_ACK directly.
  - done at cycle 177 (CLK_DIV=4).
- start pulsed every cycle during a transfer:
  - Exactly one transaction.
  - busy stays 1 until done.
  - No extra START on the bus.
- rst asserted during bit 3 of ADDR:
  - scl_oe=0, sda_oe=0, busy=0 immediately.
  - A new write after reset completes normally.
- CLK_DIV=1, write 0xFF with a data NACK:
  - START/STOP edge order correct: SDA falls while SCL is high at START and rises while SCL is high at STOP.
  - ack_err=1.
  - done at cycle 81.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the single-byte I2C initiator: FSM states, R/W and ACK levels,
// and the per-state open-drain drive pattern for each quarter of a bit-time.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_NACK,
    ST_STOP
  } state_e;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_ACK   = 1'b0;

  // Returns {scl_oe, sda_oe}; b is the data bit currently on the wire.
  function automatic logic [1:0] line_drive(state_e st, logic [1:0] q, logic b);
    logic scl_low;
    scl_low = (q == 2'd0) || (q == 2'd3);
    case (st)
      ST_START:                                         line_drive = {1'b0, q[1]};
      ST_ADDR, ST_WRITE:                                line_drive = {scl_low, ~b};
      ST_ADDR_ACK, ST_WRITE_ACK, ST_READ, ST_READ_NACK: line_drive = {scl_low, 1'b0};
      ST_STOP:                                          line_drive = {q == 2'd0, q != 2'd3};
      default:                                          line_drive = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Request/response and open-drain bus signals of the I2C initiator.
// master = the controller side, slave = the requesting logic plus bus pads.
interface i2c_master_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  modport master (
    input  start, rw, addr, wdata, sda_in,
    output busy, done, ack_err, rdata, scl_oe, sda_oe
  );

  modport slave (
    output start, rw, addr, wdata, sda_in,
    input  busy, done, ack_err, rdata, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_clk_div.sv
// Quarter-bit tick generator: one-cycle tick every CLK_DIV cycles, held at zero by clr.
// Latency: first tick CLK_DIV cycles after clr drops; no backpressure.
module i2c_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clr || tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, {addr,rw}, one data byte, ACK slots, STOP; done after 20 (NACK: 11) bit-times + 1.
// Backpressure: start is only taken in IDLE and not in the done cycle; requests while busy are dropped.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  i2c_master_if.master    bus
);

  state_e     state;
  logic [1:0] q;
  logic [2:0] bit_cnt;
  logic [7:0] tx;
  logic [7:0] rx;
  logic [7:0] wbyte;
  logic       rw_q;
  logic       ack_smp;
  logic       busy_q;
  logic       done_q;
  logic       ack_err_q;
  logic [7:0] rdata_q;
  logic       scl_oe_q;
  logic       sda_oe_q;
  logic       tick;

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_IDLE),
    .tick (tick)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ack_err = ack_err_q;
  assign bus.rdata   = rdata_q;
  assign bus.scl_oe  = scl_oe_q;
  assign bus.sda_oe  = sda_oe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      q         <= 2'd0;
      bit_cnt   <= 3'd0;
      tx        <= 8'd0;
      rx        <= 8'd0;
      wbyte     <= 8'd0;
      rw_q      <= 1'b0;
      ack_smp   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rdata_q   <= 8'd0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Line drive trails the phase registers by one cycle; ordering between quarters is kept.
      {scl_oe_q, sda_oe_q} <= line_drive(state, q, tx[7]);
      if (state == ST_IDLE) begin
        if (bus.start && !done_q) begin
          tx        <= {bus.addr, bus.rw};
          wbyte     <= bus.wdata;
          rw_q      <= bus.rw;
          ack_err_q <= 1'b0;
          busy_q    <= 1'b1;
          q         <= 2'd0;
          bit_cnt   <= 3'd0;
          state     <= ST_START;
        end
      end else if (tick) begin
        q <= q + 2'd1;
        if (q == 2'd2) begin
          ack_smp <= bus.sda_in;
          if (state == ST_READ) rx <= {rx[6:0], bus.sda_in};
        end
        if (q == 2'd3) begin
          case (state)
            ST_START: state <= ST_ADDR;
            ST_ADDR, ST_WRITE, ST_READ: begin
              tx      <= {tx[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (state)
                  ST_ADDR:  state <= ST_ADDR_ACK;
                  ST_WRITE: state <= ST_WRITE_ACK;
                  default: begin
                    rdata_q <= rx;
                    state   <= ST_READ_NACK;
                  end
                endcase
              end
            end
            ST_ADDR_ACK: begin
              if (ack_smp != I2C_ACK) begin
                ack_err_q <= 1'b1;
                state     <= ST_STOP;
              end else if (rw_q == I2C_READ) begin
                state <= ST_READ;
              end else begin
                tx    <= wbyte;
                state <= ST_WRITE;
              end
            end
            ST_WRITE_ACK: begin
              if (ack_smp != I2C_ACK) ack_err_q <= 1'b1;
              state <= ST_STOP;
            end
            ST_READ_NACK: state <= ST_STOP;
            ST_STOP: begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: table of single transactions plus hand-written corner sequences,
// with a behavioural responder on each open-drain bus.
module tb_i2c_master;
  import i2c_pkg::*;

  typedef struct {
    logic        pscl;
    logic        psda;
    bit          active;
    int          rise;
    logic        oe;
    logic [17:0] bits;
    int          nrise;
    int          starts;
    int          stops;
    logic        ack_addr;
    logic        ack_data;
    logic [7:0]  rbyte;
  } resp_t;

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic        ack_addr;
    logic        ack_data;
    logic [7:0]  rbyte;
    logic        exp_err;
    logic        chk_rdata;
    logic [7:0]  exp_rdata;
    int          exp_lat;
    int          exp_n;
    logic [17:0] exp_bits;
  } vec_t;

  logic  clk;
  logic  rst;
  resp_t ra, rb;
  logic  ra_oe, rb_oe;
  int    n_checks = 0;
  int    n_fail = 0;
  vec_t  vecs[5];

  i2c_master_if ifa();
  i2c_master_if ifb();

  assign ifa.sda_in = !(ifa.sda_oe || ra_oe);
  assign ifb.sda_in = !(ifb.sda_oe || rb_oe);

  i2c_master #(.CLK_DIV(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  i2c_master #(.CLK_DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder: slot 1-8 address, 9 address ACK, 10-17 data, 18 data ACK/NACK.
  function automatic resp_t resp_step(resp_t s, logic scl, logic sda);
    resp_t n;
    int    nx;
    n = s;
    if (s.pscl && scl && s.psda && !sda) begin
      n.starts = s.starts + 1;
      n.active = 1'b1;
      n.rise   = 0;
      n.bits   = '0;
      n.oe     = 1'b0;
    end else if (s.pscl && scl && !s.psda && sda) begin
      n.stops = s.stops + 1;
      if (s.active) n.nrise = s.rise - 1;
      n.active = 1'b0;
      n.oe     = 1'b0;
    end else if (s.active && !s.pscl && scl) begin
      n.rise = s.rise + 1;
      if (n.rise <= 18) n.bits[18 - n.rise] = sda;
    end else if (s.active && s.pscl && !scl) begin
      nx   = s.rise + 1;
      n.oe = 1'b0;
      if (nx == 9) n.oe = s.ack_addr;
      else if (nx >= 10 && nx <= 17 && s.bits[10] && s.ack_addr) n.oe = !s.rbyte[17 - nx];
      else if (nx == 18 && !s.bits[10]) n.oe = s.ack_data;
    end
    n.pscl = scl;
    n.psda = sda;
    return n;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      ra = resp_step(ra, !ifa.scl_oe, !(ifa.sda_oe || ra_oe));
      ra_oe = ra.oe;
      rb = resp_step(rb, !ifb.scl_oe, !(ifb.sda_oe || rb_oe));
      rb_oe = rb.oe;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic resp_cfg(input bit sel_b, input logic aa, input logic ad, input logic [7:0] rbyte);
    resp_t c;
    c = sel_b ? rb : ra;
    c.ack_addr = aa;
    c.ack_data = ad;
    c.rbyte    = rbyte;
    c.starts   = 0;
    c.stops    = 0;
    c.nrise    = 0;
    if (sel_b) rb = c;
    else ra = c;
  endtask

  task automatic drive_req(input bit sel_b, input logic st, input logic rw,
                           input logic [6:0] addr, input logic [7:0] wdata);
    if (sel_b) begin
      ifb.start = st; ifb.rw = rw; ifb.addr = addr; ifb.wdata = wdata;
    end else begin
      ifa.start = st; ifa.rw = rw; ifa.addr = addr; ifa.wdata = wdata;
    end
  endtask

  // Called #1 after a rising edge; returns cycles from the start cycle to the done cycle (-1 on timeout).
  task automatic do_txn(input bit sel_b, input logic rw, input logic [6:0] addr,
                        input logic [7:0] wdata, output int lat, output int gaps);
    lat  = -1;
    gaps = 0;
    drive_req(sel_b, 1'b1, rw, addr, wdata);
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (n == 1) drive_req(sel_b, 1'b0, rw, addr, wdata);
      if (sel_b ? ifb.done : ifa.done) begin
        lat = n;
        break;
      end
      if (!(sel_b ? ifb.busy : ifa.busy)) gaps++;
    end
  endtask

  initial begin
    int lat, gaps, sh, d1, d2;
    logic b322, b323;

    ra = '{pscl: 1'b1, psda: 1'b1, default: '0};
    rb = '{pscl: 1'b1, psda: 1'b1, default: '0};
    ra_oe = 1'b0;
    rb_oe = 1'b0;
    rst = 1'b1;
    drive_req(1'b0, 1'b0, I2C_WRITE, 7'h00, 8'h00);
    drive_req(1'b1, 1'b0, I2C_WRITE, 7'h00, 8'h00);

    vecs[0] = '{rw: I2C_WRITE, addr: 7'h55, wdata: 8'hA5, ack_addr: 1'b1, ack_data: 1'b1, rbyte: 8'h00,
                exp_err: 1'b0, chk_rdata: 1'b0, exp_rdata: 8'h00, exp_lat: 321, exp_n: 18,
                exp_bits: {8'b10101010, 1'b0, 8'b10100101, 1'b0}};
    vecs[1] = '{rw: I2C_READ, addr: 7'h55, wdata: 8'h00, ack_addr: 1'b1, ack_data: 1'b0, rbyte: 8'h3C,
                exp_err: 1'b0, chk_rdata: 1'b1, exp_rdata: 8'h3C, exp_lat: 321, exp_n: 18,
                exp_bits: {8'b10101011, 1'b0, 8'b00111100, 1'b1}};
    vecs[2] = '{rw: I2C_WRITE, addr: 7'h55, wdata: 8'h81, ack_addr: 1'b0, ack_data: 1'b0, rbyte: 8'h00,
                exp_err: 1'b1, chk_rdata: 1'b0, exp_rdata: 8'h00, exp_lat: 177, exp_n: 9,
                exp_bits: {8'b10101010, 1'b1, 9'b0}};
    vecs[3] = '{rw: I2C_WRITE, addr: 7'h2A, wdata: 8'h3C, ack_addr: 1'b1, ack_data: 1'b0, rbyte: 8'h00,
                exp_err: 1'b1, chk_rdata: 1'b0, exp_rdata: 8'h00, exp_lat: 321, exp_n: 18,
                exp_bits: {8'b01010100, 1'b0, 8'b00111100, 1'b1}};
    vecs[4] = '{rw: I2C_READ, addr: 7'h13, wdata: 8'hFF, ack_addr: 1'b1, ack_data: 1'b1, rbyte: 8'hC3,
                exp_err: 1'b0, chk_rdata: 1'b1, exp_rdata: 8'hC3, exp_lat: 321, exp_n: 18,
                exp_bits: {8'b00100111, 1'b0, 8'b11000011, 1'b1}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.done, 0);
    check("rst_ack_err", ifa.ack_err, 0);
    check("rst_rdata", ifa.rdata, 0);
    check("rst_scl_oe", ifa.scl_oe, 0);
    check("rst_sda_oe", ifa.sda_oe, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_lines", {ifa.scl_oe, ifa.sda_oe, ifa.busy}, 0);

    for (int i = 0; i < 5; i++) begin
      resp_cfg(1'b0, vecs[i].ack_addr, vecs[i].ack_data, vecs[i].rbyte);
      do_txn(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, lat, gaps);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_busy_gaps", i), gaps, 0);
      check($sformatf("v%0d_ack_err", i), ifa.ack_err, vecs[i].exp_err);
      if (vecs[i].chk_rdata) check($sformatf("v%0d_rdata", i), ifa.rdata, vecs[i].exp_rdata);
      repeat (4) @(posedge clk);
      #1;
      sh = 18 - vecs[i].exp_n;
      check($sformatf("v%0d_starts", i), ra.starts, 1);
      check($sformatf("v%0d_stops", i), ra.stops, 1);
      check($sformatf("v%0d_nbits", i), ra.nrise, vecs[i].exp_n);
      check($sformatf("v%0d_sda_bits", i), 32'(ra.bits >> sh), 32'(vecs[i].exp_bits >> sh));
      repeat (5) @(posedge clk);
      #1;
    end

    // start held high: ignored while busy and in the done cycle, taken once one cycle later
    resp_cfg(1'b0, 1'b1, 1'b1, 8'h00);
    drive_req(1'b0, 1'b1, I2C_WRITE, 7'h55, 8'hA5);
    d1 = -1; d2 = -1; gaps = 0; b322 = 1'bx; b323 = 1'bx;
    for (int n = 1; n <= 1400; n++) begin
      @(posedge clk); #1;
      if (n == 323) ifa.start = 1'b0;
      if (n == 322) b322 = ifa.busy;
      if (n == 323) b323 = ifa.busy;
      if (n < 321 && !ifa.busy) gaps++;
      if (ifa.done) begin
        if (d1 < 0) d1 = n;
        else begin
          d2 = n;
          break;
        end
      end
    end
    check("hold_first_done", d1, 321);
    check("hold_busy_gaps", gaps, 0);
    check("hold_busy_in_done_plus1", b322, 0);
    check("hold_busy_in_done_plus2", b323, 1);
    check("hold_second_done", d2, 643);
    repeat (40) @(posedge clk);
    #1;
    check("hold_starts", ra.starts, 2);
    check("hold_stops", ra.stops, 2);
    check("hold_idle_after", ifa.busy, 0);

    // reset during address bit 3
    resp_cfg(1'b0, 1'b1, 1'b1, 8'h00);
    drive_req(1'b0, 1'b1, I2C_WRITE, 7'h55, 8'hA5);
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk); #1;
      if (n == 1) ifa.start = 1'b0;
    end
    check("mid_busy", ifa.busy, 1);
    check("mid_sda_oe", ifa.sda_oe, 1);
    rst = 1'b1;
    #1;
    check("arst_scl_oe", ifa.scl_oe, 0);
    check("arst_sda_oe", ifa.sda_oe, 0);
    check("arst_busy", ifa.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    resp_cfg(1'b0, 1'b1, 1'b1, 8'h00);
    do_txn(1'b0, I2C_WRITE, 7'h55, 8'hA5, lat, gaps);
    check("post_rst_latency", lat, 321);
    check("post_rst_ack_err", ifa.ack_err, 0);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_bits", ra.bits, {8'b10101010, 1'b0, 8'b10100101, 1'b0});
    check("post_rst_stops", ra.stops, 1);

    // CLK_DIV=1: write 0xFF, data NACK
    resp_cfg(1'b1, 1'b1, 1'b0, 8'h00);
    do_txn(1'b1, I2C_WRITE, 7'h55, 8'hFF, lat, gaps);
    check("div1_latency", lat, 81);
    check("div1_ack_err", ifb.ack_err, 1);
    check("div1_busy_gaps", gaps, 0);
    repeat (4) @(posedge clk);
    #1;
    check("div1_start_edge", rb.starts, 1);
    check("div1_stop_edge", rb.stops, 1);
    check("div1_nbits", rb.nrise, 18);
    check("div1_bits", rb.bits, {8'b10101010, 1'b0, 8'b11111111, 1'b1});
    check("div1_lines_released", {ifb.scl_oe, ifb.sda_oe}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
